// File: rtl/sdram_arbiter.sv
// Central SDRAM command arbiter: grants the PHY to the init, refresh, write or read engine
// and registers the owner's command/address/bank onto the SDRAM pins.
module sdram_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic [3:0]  init_cmds,
  input  logic [10:0] init_addr,
  input  logic [1:0]  init_ba,
  input  logic        atref_req,
  output logic        atref_en,
  input  logic        atref_done,
  input  logic [3:0]  atref_cmds,
  input  logic [10:0] atref_addr,
  input  logic [1:0]  atref_ba,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        wr_done,
  input  logic [3:0]  wr_cmds,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_ba,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        rd_done,
  input  logic [3:0]  rd_cmds,
  input  logic [10:0] rd_addr,
  input  logic [1:0]  rd_ba,
  output logic [3:0]  sdr_cmds,
  output logic [10:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        err_timeout
);

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_IDLE  = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_t;

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0]    CMD_NOP  = 4'b0111;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic          last_wr_r, last_wr_s;
  logic          atref_en_s, wr_en_s, rd_en_s;
  logic          done_s, timeout_s;
  logic [3:0]    cmd_s;
  logic [10:0]   addr_s;
  logic [1:0]    ba_s;

  // Done strobe of the current owner only; other engines' done pulses are ignored.
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      ST_AREF:  done_s = atref_done;
      ST_WRITE: done_s = wr_done;
      ST_READ:  done_s = rd_done;
      default:  done_s = 1'b0;
    endcase
  end

  // Next-state, grant and round-robin decision.
  always_comb begin
    state_s    = state_r;
    last_wr_s  = last_wr_r;
    atref_en_s = 1'b0;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_done) state_s = ST_IDLE;
        else           state_s = ST_INIT;
      end
      ST_IDLE: begin
        // Refresh first; a write loses a tie only when the previous grant was a write.
        if (atref_req) begin
          state_s    = ST_AREF;
          atref_en_s = 1'b1;
        end else if (wr_req && (!rd_req || !last_wr_r)) begin
          state_s   = ST_WRITE;
          wr_en_s   = 1'b1;
          last_wr_s = 1'b1;
        end else if (rd_req) begin
          state_s   = ST_READ;
          rd_en_s   = 1'b1;
          last_wr_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        if (done_s) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_INIT;
    endcase
  end

  // PHY source select by current owner; idle drives NOP.
  always_comb begin
    cmd_s  = CMD_NOP;
    addr_s = 11'd0;
    ba_s   = 2'd0;
    case (state_r)
      ST_INIT:  begin cmd_s = init_cmds;  addr_s = init_addr;  ba_s = init_ba;  end
      ST_AREF:  begin cmd_s = atref_cmds; addr_s = atref_addr; ba_s = atref_ba; end
      ST_WRITE: begin cmd_s = wr_cmds;    addr_s = wr_addr;    ba_s = wr_ba;    end
      ST_READ:  begin cmd_s = rd_cmds;    addr_s = rd_addr;    ba_s = rd_ba;    end
      default:  begin cmd_s = CMD_NOP;    addr_s = 11'd0;      ba_s = 2'd0;     end
    endcase
  end

  // State, grant pulses, timeout counter and registered PHY pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      last_wr_r   <= 1'b0;
      cnt_r       <= '0;
      atref_en    <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      err_timeout <= 1'b0;
      sdr_cmds    <= CMD_NOP;
      sdr_addr    <= 11'd0;
      sdr_ba      <= 2'd0;
    end else begin
      state_r   <= state_s;
      last_wr_r <= last_wr_s;
      atref_en  <= atref_en_s;
      wr_en     <= wr_en_s;
      rd_en     <= rd_en_s;
      sdr_cmds  <= cmd_s;
      sdr_addr  <= addr_s;
      sdr_ba    <= ba_s;
      // Counts only while staying in a service state, so it exits before reaching TIMEOUT.
      if ((state_s == state_r) && (state_r != ST_IDLE) && (state_r != ST_INIT))
        cnt_r <= cnt_r + 1'b1;
      else
        cnt_r <= '0;
      if (timeout_s) err_timeout <= 1'b1;
      else           err_timeout <= err_timeout;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter: init gating, priority, round-robin,
// passthrough, timeout and mid-grant reset.
module tb_sdram_arbiter;

  localparam int TIMEOUT = 16;
  localparam logic [3:0] NOP = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done, atref_req, atref_done, wr_req, wr_done, rd_req, rd_done;
  logic [3:0]  init_cmds, atref_cmds, wr_cmds, rd_cmds;
  logic [10:0] init_addr, atref_addr, wr_addr, rd_addr;
  logic [1:0]  init_ba, atref_ba, wr_ba, rd_ba;
  logic        atref_en, wr_en, rd_en, err_timeout;
  logic [3:0]  sdr_cmds;
  logic [10:0] sdr_addr;
  logic [1:0]  sdr_ba;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_done(init_done), .init_cmds(init_cmds), .init_addr(init_addr), .init_ba(init_ba),
    .atref_req(atref_req), .atref_en(atref_en), .atref_done(atref_done),
    .atref_cmds(atref_cmds), .atref_addr(atref_addr), .atref_ba(atref_ba),
    .wr_req(wr_req), .wr_en(wr_en), .wr_done(wr_done),
    .wr_cmds(wr_cmds), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .rd_req(rd_req), .rd_en(rd_en), .rd_done(rd_done),
    .rd_cmds(rd_cmds), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .sdr_cmds(sdr_cmds), .sdr_addr(sdr_addr), .sdr_ba(sdr_ba),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    init_done = 1'b0; atref_req = 1'b0; atref_done = 1'b0;
    wr_req = 1'b0; wr_done = 1'b0; rd_req = 1'b0; rd_done = 1'b0;
    init_cmds = 4'd0;  init_addr = 11'd0;  init_ba = 2'd0;
    atref_cmds = 4'd0; atref_addr = 11'd0; atref_ba = 2'd0;
    wr_cmds = 4'd0;    wr_addr = 11'd0;    wr_ba = 2'd0;
    rd_cmds = 4'd0;    rd_addr = 11'd0;    rd_ba = 2'd0;
    repeat (3) tick();
    chk("rst_cmds", sdr_cmds, NOP);
    chk("rst_addr", sdr_addr, 11'd0);
    chk("rst_ba", sdr_ba, 2'd0);
    chk("rst_en", {atref_en, wr_en, rd_en}, 3'b000);
    chk("rst_err", err_timeout, 1'b0);

    // T1: init engine owns the PHY, requests ignored until init_done
    init_cmds = 4'b0010; init_addr = 11'h123; atref_req = 1'b1; rst_n = 1'b1;
    tick();
    chk("t1_init_cmds", sdr_cmds, 4'b0010);
    chk("t1_init_addr", sdr_addr, 11'h123);
    chk("t1_atref_gated", atref_en, 1'b0);
    tick();
    chk("t1_atref_gated2", atref_en, 1'b0);
    init_done = 1'b1;
    tick();
    atref_req = 1'b0; init_done = 1'b0;
    chk("t1_last_init_cmds", sdr_cmds, 4'b0010);
    chk("t1_no_grant", atref_en, 1'b0);
    tick();
    chk("t1_idle_nop", sdr_cmds, NOP);
    chk("t1_idle_addr", sdr_addr, 11'd0);

    // T2: refresh beats write; one idle cycle before the write grant
    atref_req = 1'b1; wr_req = 1'b1; atref_cmds = 4'b0001; atref_addr = 11'h400;
    tick();
    chk("t2_atref_en", atref_en, 1'b1);
    chk("t2_wr_en_low", wr_en, 1'b0);
    atref_req = 1'b0;
    tick();
    chk("t2_atref_pulse", atref_en, 1'b0);
    chk("t2_atref_cmds", sdr_cmds, 4'b0001);
    chk("t2_atref_addr", sdr_addr, 11'h400);
    atref_done = 1'b1;
    tick();
    atref_done = 1'b0;
    chk("t2_idle_gap", wr_en, 1'b0);
    tick();
    chk("t2_wr_en", wr_en, 1'b1);
    chk("t2_grant_cycle_nop", sdr_cmds, NOP);
    wr_req = 1'b0;

    // T4: write owner passthrough; read drive and rd_done never take effect
    wr_cmds = 4'b0100; wr_addr = 11'h155; wr_ba = 2'b10;
    rd_cmds = 4'b0101; rd_addr = 11'h2aa; rd_ba = 2'b01;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("t4_cmds", sdr_cmds, 4'b0100);
    chk("t4_addr", sdr_addr, 11'h155);
    chk("t4_ba", sdr_ba, 2'b10);
    chk("t4_wr_pulse", wr_en, 1'b0);
    tick();
    chk("t4_rd_done_ignored", sdr_cmds, 4'b0100);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("t4_last_wr_cmds", sdr_cmds, 4'b0100);
    tick();
    chk("t4_idle_nop", sdr_cmds, NOP);
    chk("t4_idle_ba", sdr_ba, 2'd0);

    // T5b: read done on its 16th cycle wins over timeout
    rd_req = 1'b1;
    tick();
    chk("t5b_rd_en", rd_en, 1'b1);
    rd_req = 1'b0;
    repeat (15) tick();
    chk("t5b_still_read", sdr_cmds, 4'b0101);
    chk("t5b_rd_addr", sdr_addr, 11'h2aa);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("t5b_no_err", err_timeout, 1'b0);
    tick();
    chk("t5b_idle_nop", sdr_cmds, NOP);
    chk("t5b_no_err2", err_timeout, 1'b0);

    // T3: both requests held; last grant was a read, so order is W,R,W,R
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (!(wr_en || rd_en) && w < 8) begin
        tick();
        w++;
      end
      chk("t3_wait", w, 1);
      chk("t3_wr_en", wr_en, (g % 2 == 0) ? 1'b1 : 1'b0);
      chk("t3_rd_en", rd_en, (g % 2 == 1) ? 1'b1 : 1'b0);
      for (int c = 0; c < 9; c++) begin
        tick();
        chk("t3_no_en_in_service", {wr_en, rd_en}, 2'b00);
      end
      if (g % 2 == 0) wr_done = 1'b1;
      else            rd_done = 1'b1;
      tick();
      wr_done = 1'b0; rd_done = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("t3_last_read_cmds", sdr_cmds, 4'b0101);

    // T5a: read without done is force-released after 16 cycles
    tick();
    rd_req = 1'b1;
    tick();
    chk("t5a_rd_en", rd_en, 1'b1);
    rd_req = 1'b0;
    repeat (15) tick();
    chk("t5a_err_before", err_timeout, 1'b0);
    chk("t5a_still_read", sdr_cmds, 4'b0101);
    tick();
    chk("t5a_err_set", err_timeout, 1'b1);
    tick();
    chk("t5a_idle_nop", sdr_cmds, NOP);
    chk("t5a_err_sticky", err_timeout, 1'b1);
    wr_req = 1'b1;
    tick();
    chk("t5a_wr_after_timeout", wr_en, 1'b1);
    wr_req = 1'b0;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    tick();
    chk("t5a_err_sticky2", err_timeout, 1'b1);

    // T6: reset during a refresh grant aborts at once
    atref_req = 1'b1;
    tick();
    chk("t6_atref_en", atref_en, 1'b1);
    atref_req = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("t6_en_cleared", {atref_en, wr_en, rd_en}, 3'b000);
    chk("t6_nop", sdr_cmds, NOP);
    chk("t6_addr", sdr_addr, 11'd0);
    chk("t6_err_cleared", err_timeout, 1'b0);
    rst_n = 1'b1; init_cmds = 4'b0011; atref_req = 1'b1;
    tick();
    chk("t6_back_in_init", sdr_cmds, 4'b0011);
    chk("t6_atref_gated", atref_en, 1'b0);
    atref_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
